// File: rtl/mem_fill_pkg.sv
// Shared types and defaults for the memory fill engine.
//   fill_state_t : engine state encoding (IDLE, LOAD, WRITE, DONE)
//   ADDR_W_DEF   : default address width
//   DATA_W_DEF   : default data word width
package mem_fill_pkg;

  localparam int unsigned ADDR_W_DEF = 8;
  localparam int unsigned DATA_W_DEF = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } fill_state_t;

endpackage

// File: rtl/mem_fill_fsm.sv
// Control FSM for mem_fill_engine: state register, next-state logic and
// control decode.
// Ports:
//   clock, reset  : rising-edge clock, synchronous active-high reset
//   start         : fill request (honoured in IDLE only)
//   abort         : stop request
//   mem_ready     : RAM accepts the current write
//   last_word     : remaining counter is zero (current word is the last)
//   busy          : high in LOAD and WRITE
//   done          : high in DONE
//   mem_we        : high in WRITE
//   load_en       : capture the fill parameters (IDLE with start)
//   step_en       : a write handshake completed; advance address/data
//   abort_set     : the fill ends cut short; set the aborted flag
module mem_fill_fsm
  import mem_fill_pkg::*;
(
  input  logic clock,
  input  logic reset,
  input  logic start,
  input  logic abort,
  input  logic mem_ready,
  input  logic last_word,
  output logic busy,
  output logic done,
  output logic mem_we,
  output logic load_en,
  output logic step_en,
  output logic abort_set
);

  fill_state_t state_q;
  fill_state_t state_d;

  always_ff @(posedge clock) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:  if (start) state_d = LOAD;
      LOAD:  state_d = abort ? DONE : WRITE;
      WRITE: if ((mem_ready && last_word) || abort) state_d = DONE;
      DONE:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy      = (state_q == LOAD) || (state_q == WRITE);
    done      = (state_q == DONE);
    mem_we    = (state_q == WRITE);
    load_en   = (state_q == IDLE) && start;
    step_en   = (state_q == WRITE) && mem_ready;
    // Completing the final word wins over a simultaneous abort.
    abort_set = ((state_q == LOAD) && abort) ||
                ((state_q == WRITE) && abort && !(mem_ready && last_word));
  end

endmodule

// File: rtl/mem_fill_engine.sv
// Memory fill engine: writes a constant (or, optionally, incrementing)
// pattern to a contiguous, wrapping address range of a single-port RAM,
// one word per mem_we/mem_ready handshake, then pulses done with status.
// Optional feature macro: MEM_FILL_INC_PATTERN_EN enables mode=1
// (incrementing data); without it mode is ignored and no incrementer is built.
// Ports:
//   clock, reset          : rising-edge clock, synchronous active-high reset
//   start                 : fill request, sampled in IDLE only
//   base_addr, length     : first address; word count minus one
//   fill_data, mode       : pattern / first value; 1 = incrementing
//   abort                 : cut the fill short at the next handshake boundary
//   mem_ready             : RAM accepts the write this cycle
//   mem_we, mem_addr,
//   mem_wdata             : RAM write port (address/data zero when idle)
//   busy                  : high in LOAD and WRITE
//   done, aborted         : one-cycle completion pulse and its status
module mem_fill_engine
  import mem_fill_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned DATA_W = DATA_W_DEF
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W-1:0] length,
  input  logic [DATA_W-1:0] fill_data,
  input  logic              mode,
  input  logic              abort,
  input  logic              mem_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              busy,
  output logic              done,
  output logic              aborted
);

  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W-1:0] remaining_q;
  logic [DATA_W-1:0] data_q;
  logic              aborted_q;
  logic              last_word;
  logic              load_en;
  logic              step_en;
  logic              abort_set;
  logic              fsm_done;

  assign last_word = (remaining_q == '0);

  mem_fill_fsm u_fsm (
    .clock     (clock),
    .reset     (reset),
    .start     (start),
    .abort     (abort),
    .mem_ready (mem_ready),
    .last_word (last_word),
    .busy      (busy),
    .done      (fsm_done),
    .mem_we    (mem_we),
    .load_en   (load_en),
    .step_en   (step_en),
    .abort_set (abort_set)
  );

  // Parameters are captured on the IDLE->LOAD transition, so the LOAD
  // cycle already presents base/length/pattern in the working registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      addr_q      <= '0;
      remaining_q <= '0;
    end else if (load_en) begin
      addr_q      <= base_addr;
      remaining_q <= length;
    end else if (step_en) begin
      addr_q      <= addr_q + ADDR_W'(1);
      remaining_q <= remaining_q - ADDR_W'(1);
    end
  end

`ifdef MEM_FILL_INC_PATTERN_EN
  logic mode_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      data_q <= '0;
      mode_q <= 1'b0;
    end else if (load_en) begin
      data_q <= fill_data;
      mode_q <= mode;
    end else if (step_en && mode_q) begin
      data_q <= data_q + DATA_W'(1);
    end
  end
`else
  logic unused_mode;
  assign unused_mode = mode;

  always_ff @(posedge clock) begin
    if (reset)        data_q <= '0;
    else if (load_en) data_q <= fill_data;
  end
`endif

  always_ff @(posedge clock) begin
    if (reset)          aborted_q <= 1'b0;
    else if (load_en)   aborted_q <= 1'b0;
    else if (abort_set) aborted_q <= 1'b1;
  end

  assign done      = fsm_done;
  assign aborted   = fsm_done && aborted_q;
  assign mem_addr  = mem_we ? addr_q : '0;
  assign mem_wdata = mem_we ? data_q : '0;

endmodule

// File: tb/tb_mem_fill_engine.sv
// Scoreboard bench for mem_fill_engine: directed fills push expected
// writes/completions into queues; a negedge monitor pops and compares.
module tb_mem_fill_engine;

  logic        clock = 1'b0;
  logic        reset;
  logic        start;
  logic [7:0]  base_addr;
  logic [7:0]  length;
  logic [15:0] fill_data;
  logic        mode;
  logic        abort;
  logic        mem_ready;
  logic        mem_we;
  logic [7:0]  mem_addr;
  logic [15:0] mem_wdata;
  logic        busy;
  logic        done;
  logic        aborted;

  mem_fill_engine #(.ADDR_W(8), .DATA_W(16)) dut (
    .clock     (clock),
    .reset     (reset),
    .start     (start),
    .base_addr (base_addr),
    .length    (length),
    .fill_data (fill_data),
    .mode      (mode),
    .abort     (abort),
    .mem_ready (mem_ready),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .busy      (busy),
    .done      (done),
    .aborted   (aborted)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc = cyc + 1;

  typedef struct packed {
    logic [7:0]  a;
    logic [15:0] d;
  } wr_t;

  wr_t  exp_wr[$];
  bit   exp_done[$];
  wr_t  e_wr;
  bit   e_ab;

  int n_checks = 0;
  int n_fail = 0;
  int done_count = 0;
  int last_done_cyc = -1;
  int first_we_cyc = -1;

  logic        prev_we = 1'b0;
  logic        prev_rdy = 1'b0;
  logic        prev_rst = 1'b1;
  logic [7:0]  prev_a = '0;
  logic [15:0] prev_d = '0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  // Monitor / scoreboard
  always @(negedge clock) begin
    if (!reset) begin
      if (mem_we && !prev_we) first_we_cyc = cyc;
      if (prev_we && !prev_rdy && !prev_rst) begin
        check("hold_we", 32'(mem_we), 32'd1);
        check("hold_addr", 32'(mem_addr), 32'(prev_a));
        check("hold_data", 32'(mem_wdata), 32'(prev_d));
      end
      if (mem_we && mem_ready) begin
        if (exp_wr.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_write: got addr 0x%0h data 0x%0h, expected no write", mem_addr, mem_wdata);
        end else begin
          e_wr = exp_wr.pop_front();
          check("wr_addr", 32'(mem_addr), 32'(e_wr.a));
          check("wr_data", 32'(mem_wdata), 32'(e_wr.d));
        end
      end
      if (done) begin
        done_count++;
        last_done_cyc = cyc;
        if (exp_done.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_done: got done aborted=%0b, expected no done", aborted);
        end else begin
          e_ab = exp_done.pop_front();
          check("done_aborted", 32'(aborted), 32'(e_ab));
        end
      end
    end
    prev_we  <= mem_we;
    prev_rdy <= mem_ready;
    prev_rst <= reset;
    prev_a   <= mem_addr;
    prev_d   <= mem_wdata;
  end

  task automatic push_wr(input logic [7:0] a, input logic [15:0] d);
    wr_t w;
    w.a = a;
    w.d = d;
    exp_wr.push_back(w);
  endtask

  // Issues start in the current cycle (t); returns in the LOAD cycle with
  // the parameter inputs scrambled to prove they were latched.
  task automatic kick(input logic [7:0] b, input logic [7:0] l, input logic [15:0] d,
                      input logic m, output int t);
    base_addr = b;
    length    = l;
    fill_data = d;
    mode      = m;
    start     = 1'b1;
    t = cyc;
    @(posedge clock); #1;
    start     = 1'b0;
    base_addr = 8'hC3;
    length    = 8'h77;
    fill_data = 16'hDEAD;
    mode      = ~m;
    check("load_busy", 32'(busy), 32'd1);
    check("load_we", 32'(mem_we), 32'd0);
  endtask

  task automatic wait_done(input string nm, input int exp_cyc);
    int start_cnt;
    int budget;
    start_cnt = done_count;
    budget = 0;
    while (done_count == start_cnt && budget < 50) begin
      @(posedge clock); #1;
      budget++;
    end
    if (done_count == start_cnt) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s_timeout: got no done within 50 cycles, expected done at cycle %0d", nm, exp_cyc);
    end else begin
      check({nm, "_done_cyc"}, 32'(last_done_cyc), 32'(exp_cyc));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got simulation still running, expected completion");
    $fatal(1, "watchdog expired");
  end

  int t;
  int dc;

  initial begin
    reset = 1'b1; start = 1'b0; base_addr = '0; length = '0;
    fill_data = '0; mode = 1'b0; abort = 1'b0; mem_ready = 1'b1;
    repeat (3) @(posedge clock);
    @(negedge clock);
    check("rst_we", 32'(mem_we), 32'd0);
    check("rst_addr", 32'(mem_addr), 32'd0);
    check("rst_data", 32'(mem_wdata), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_aborted", 32'(aborted), 32'd0);
    @(posedge clock); #1;
    reset = 1'b0;
    @(posedge clock); #1;

    // Constant fill, ready tied high
    for (int i = 0; i < 4; i++) push_wr(8'(8'h10 + i), 16'hA5A5);
    exp_done.push_back(1'b0);
    kick(8'h10, 8'd3, 16'hA5A5, 1'b0, t);
    wait_done("const", t + 6);
    check("const_first_we", 32'(first_we_cyc), 32'(t + 2));
    check("idle_addr", 32'(mem_addr), 32'd0);
    check("idle_busy", 32'(busy), 32'd0);

    // Wrapping address, incrementing data when built in
    push_wr(8'hFE, 16'h0007);
`ifdef MEM_FILL_INC_PATTERN_EN
    push_wr(8'hFF, 16'h0008);
    push_wr(8'h00, 16'h0009);
    push_wr(8'h01, 16'h000A);
`else
    push_wr(8'hFF, 16'h0007);
    push_wr(8'h00, 16'h0007);
    push_wr(8'h01, 16'h0007);
`endif
    exp_done.push_back(1'b0);
    kick(8'hFE, 8'd3, 16'h0007, 1'b1, t);
    wait_done("wrap", t + 6);

    // Back-pressure: ready low for the first word's first 3 WRITE cycles
    push_wr(8'h20, 16'h1234);
    push_wr(8'h21, 16'h1234);
    exp_done.push_back(1'b0);
    kick(8'h20, 8'd1, 16'h1234, 1'b0, t);
    mem_ready = 1'b0;
    repeat (4) begin @(posedge clock); #1; end
    mem_ready = 1'b1;
    wait_done("bp", t + 7);
    check("bp_first_we", 32'(first_we_cyc), 32'(t + 2));

    // Abort on the third handshake of a 10-word fill
    for (int i = 0; i < 3; i++) push_wr(8'(8'h40 + i), 16'hBEEF);
    exp_done.push_back(1'b1);
    kick(8'h40, 8'd9, 16'hBEEF, 1'b0, t);
    repeat (3) begin @(posedge clock); #1; end
    abort = 1'b1;
    @(posedge clock); #1;
    abort = 1'b0;
    wait_done("abort", t + 5);

    // Abort together with the final handshake: completion wins
    for (int i = 0; i < 3; i++) push_wr(8'(8'h50 + i), 16'h0F0F);
    exp_done.push_back(1'b0);
    kick(8'h50, 8'd2, 16'h0F0F, 1'b0, t);
    repeat (3) begin @(posedge clock); #1; end
    abort = 1'b1;
    @(posedge clock); #1;
    abort = 1'b0;
    wait_done("abort_last", t + 5);

    // Abort during LOAD: no writes at all
    exp_done.push_back(1'b1);
    kick(8'h60, 8'd4, 16'h6666, 1'b0, t);
    abort = 1'b1;
    @(posedge clock); #1;
    abort = 1'b0;
    wait_done("abort_load", t + 2);

    // Reset in WRITE after two writes
    push_wr(8'h70, 16'h5555);
    push_wr(8'h71, 16'h5555);
    kick(8'h70, 8'd5, 16'h5555, 1'b0, t);
    repeat (3) begin @(posedge clock); #1; end
    mem_ready = 1'b0;
    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    mem_ready = 1'b1;
    check("rstw_we", 32'(mem_we), 32'd0);
    check("rstw_busy", 32'(busy), 32'd0);
    dc = done_count;
    repeat (4) begin @(posedge clock); #1; end
    check("rstw_no_done", 32'(done_count), 32'(dc));

    // Fresh fill after reset, mode=1 (constant when the feature is absent)
    push_wr(8'h80, 16'h0003);
`ifdef MEM_FILL_INC_PATTERN_EN
    push_wr(8'h81, 16'h0004);
    push_wr(8'h82, 16'h0005);
`else
    push_wr(8'h81, 16'h0003);
    push_wr(8'h82, 16'h0003);
`endif
    exp_done.push_back(1'b0);
    kick(8'h80, 8'd2, 16'h0003, 1'b1, t);
    wait_done("mode", t + 5);

    repeat (2) @(posedge clock);
    check("left_writes", 32'(exp_wr.size()), 32'd0);
    check("left_dones", 32'(exp_done.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
